// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS/2 key writer: RAM address, set-2 scan
// codes and the frame FSM state encoding.
package ps2_key_pkg;

  localparam logic [12:0] SCAN_ASCII_ADDR_DEFAULT = 13'h0310;
  localparam int          TIMEOUT_CYCLES_DEFAULT  = 5000;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_key_writer_if.sv
// RAM-side bus of the key writer plus the frame FSM state for observation.
interface ps2_key_writer_if;
  import ps2_key_pkg::*;

  // key_ram_wen acts as valid and scan_read as the consume strobe: a key is
  // taken in any cycle where both are high, and wen drops on the next edge
  // unless a new key lands in that same cycle.
  logic [12:0]  key_ram_addr;
  logic [31:0]  key_ram_wdata;
  logic         key_ram_wen;
  logic         scan_read;
  frame_state_e fsm_state;

  modport master (
    output key_ram_addr,
    output key_ram_wdata,
    output key_ram_wen,
    output fsm_state,
    input  scan_read
  );

  modport slave (
    input  key_ram_addr,
    input  key_ram_wdata,
    input  key_ram_wen,
    input  fsm_state,
    output scan_read
  );

endinterface

// File: rtl/ps2_scan_to_ascii.sv
// Combinational PS/2 set-2 make code to ASCII lookup; returns 0 for unmapped codes.
module ps2_scan_to_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] letter;

  always_comb begin
    letter = 8'h00;
    ascii  = 8'h00;
    case (code)
      8'h1C: letter = "A";  8'h32: letter = "B";  8'h21: letter = "C";
      8'h23: letter = "D";  8'h24: letter = "E";  8'h2B: letter = "F";
      8'h34: letter = "G";  8'h33: letter = "H";  8'h43: letter = "I";
      8'h3B: letter = "J";  8'h42: letter = "K";  8'h4B: letter = "L";
      8'h3A: letter = "M";  8'h31: letter = "N";  8'h44: letter = "O";
      8'h4D: letter = "P";  8'h15: letter = "Q";  8'h2D: letter = "R";
      8'h1B: letter = "S";  8'h2C: letter = "T";  8'h3C: letter = "U";
      8'h2A: letter = "V";  8'h1D: letter = "W";  8'h22: letter = "X";
      8'h35: letter = "Y";  8'h1A: letter = "Z";
      default: letter = 8'h00;
    endcase

    // Letters are stored upper case; bit 5 turns them into lower case.
    if (letter != 8'h00) begin
      ascii = shift ? letter : (letter | 8'h20);
    end else begin
      case (code)
        8'h45: ascii = "0";  8'h16: ascii = "1";  8'h1E: ascii = "2";
        8'h26: ascii = "3";  8'h25: ascii = "4";  8'h2E: ascii = "5";
        8'h36: ascii = "6";  8'h3D: ascii = "7";  8'h3E: ascii = "8";
        8'h46: ascii = "9";
        8'h29: ascii = 8'h20;
        8'h5A: ascii = 8'h0D;
        8'h66: ascii = 8'h08;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_writer.sv
// PS/2 receiver and make-code decoder that posts the latest key to the data RAM.
// Define PS2_PARITY_CHECK_EN to drop frames that fail the odd-parity check.
module ps2_key_writer
  import ps2_key_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [12:0] SCAN_ASCII_ADDR = SCAN_ASCII_ADDR_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  ps2_key_writer_if.master        bus
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic [1:0]   clk_sync;
  logic [1:0]   data_sync;
  logic         clk_prev;
  logic         fall;
  logic         data_bit;
  frame_state_e state;
  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic         parity_bit;
  logic [CW-1:0] to_cnt;
  logic         parity_ok;
  logic         frame_valid;
  logic         shift;
  logic         break_pending;
  logic [7:0]   ascii;
  logic [7:0]   ascii_q;
  logic         wen_q;

  // Idle-high reset values keep a released reset from looking like a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[1];
  assign data_bit = data_sync[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;

      if (fall) begin
        case (state)
          IDLE: if (!data_bit) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
          DATA: begin
            shreg   <= {data_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_bit;
            state      <= STOP;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && to_cnt == TO_LAST) begin
        state  <= IDLE;
        to_cnt <= '0;
      end
    end
  end

  // The code is decoded on the stop-bit strobe itself so the key lands one edge later.
  assign parity_ok   = ^{shreg, parity_bit};
  assign frame_valid = fall && (state == STOP) && data_bit && (PARITY_EN ? parity_ok : 1'b1);

  ps2_scan_to_ascii u_lookup (
    .code  (shreg),
    .shift (shift),
    .ascii (ascii)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      shift         <= 1'b0;
      break_pending <= 1'b0;
      ascii_q       <= 8'h00;
      wen_q         <= 1'b0;
    end else begin
      if (bus.scan_read) wen_q <= 1'b0;
      if (frame_valid) begin
        if (shreg == SC_EXT) begin
          // Extended prefix carries no key information of its own.
        end else if (shreg == SC_BREAK) begin
          break_pending <= 1'b1;
        end else if (break_pending) begin
          break_pending <= 1'b0;
          if (is_shift_code(shreg)) shift <= 1'b0;
        end else if (is_shift_code(shreg)) begin
          shift <= 1'b1;
        end else if (ascii != 8'h00) begin
          ascii_q <= ascii;
          wen_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.key_ram_addr  = SCAN_ASCII_ADDR;
  assign bus.key_ram_wdata = {24'h0, ascii_q};
  assign bus.key_ram_wen   = wen_q;
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_ps2_key_writer.sv
// Bench for ps2_key_writer: drives PS/2 frames bit by bit and scoreboards RAM writes.
module tb_ps2_key_writer;
  import ps2_key_pkg::*;

  localparam int HALF    = 8;
  localparam int TIMEOUT = 5000;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic scan_read = 1'b0;

  ps2_key_writer_if bus ();
  assign bus.scan_read = scan_read;

  ps2_key_writer #(
    .TIMEOUT_CYCLES  (TIMEOUT),
    .SCAN_ASCII_ADDR (13'h0310)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: bench still running at cycle %0d, expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        wen_prev   = 1'b0;
  logic [31:0] wdata_prev = 32'h0;
  int          last_fall_cyc = 0;
  bit          track_wen   = 1'b0;
  bit          wen_dropped = 1'b0;

  // A write is wen rising, or wdata changing while wen is held.
  always @(negedge clock) begin
    if (!reset && bus.key_ram_wen && (!wen_prev || bus.key_ram_wdata != wdata_prev)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", bus.key_ram_wdata, 32'h0);
      end else begin
        check_eq("write_data", bus.key_ram_wdata, exp_q.pop_front());
        check_eq("write_latency", 32'(cyc - last_fall_cyc), 32'd3);
      end
    end
    if (track_wen && !bus.key_ram_wen) wen_dropped = 1'b1;
    wen_prev   = bus.key_ram_wen;
    wdata_prev = bus.key_ram_wdata;
  end

  // ---------------- drivers ----------------
  task automatic ps2_bit(input logic b, input bit scan_at_latch);
    @(negedge clock);
    ps2_data = b;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    if (scan_at_latch) begin
      // Two sync stages put the decode strobe in the cycle after the second negedge.
      repeat (2) @(negedge clock);
      scan_read = 1'b1;
      @(negedge clock);
      scan_read = 1'b0;
      repeat (HALF - 3) @(negedge clock);
    end else begin
      repeat (HALF) @(negedge clock);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par = 1'b0,
                            input bit scan_at_latch = 1'b0);
    logic par;
    par = ~(^code) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(1'b1, scan_at_latch);
    repeat (4) @(negedge clock);
  endtask

  task automatic consume(input string tag);
    @(negedge clock);
    scan_read = 1'b1;
    @(negedge clock);
    scan_read = 1'b0;
    check_eq(tag, 32'(bus.key_ram_wen), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("reset_wen",   32'(bus.key_ram_wen), 32'd0);
    check_eq("reset_wdata", bus.key_ram_wdata, 32'h0);
    check_eq("reset_addr",  32'(bus.key_ram_addr), 32'h0310);
    check_eq("reset_state", 32'(bus.fsm_state), 32'(IDLE));

    // Single key, then consume.
    exp_q.push_back(32'h61);
    send_frame(8'h1C);
    check_eq("a_drain", 32'(exp_q.size()), 32'd0);
    check_eq("a_wen",   32'(bus.key_ram_wen), 32'd1);
    check_eq("a_addr",  32'(bus.key_ram_addr), 32'h0310);
    consume("a_consume_wen");
    check_eq("a_hold_wdata", bus.key_ram_wdata, 32'h61);

    // Shift make / break handling.
    exp_q.push_back(32'h41);
    send_frame(SC_LSHIFT);
    send_frame(8'h1C);
    check_eq("shift_drain", 32'(exp_q.size()), 32'd0);
    check_eq("shift_wdata", bus.key_ram_wdata, 32'h41);
    send_frame(SC_BREAK);
    send_frame(8'h1C);
    send_frame(SC_BREAK);
    send_frame(SC_LSHIFT);
    check_eq("break_no_write", bus.key_ram_wdata, 32'h41);
    check_eq("break_wen",      32'(bus.key_ram_wen), 32'd1);
    exp_q.push_back(32'h61);
    send_frame(8'h1C);
    check_eq("unshift_drain", 32'(exp_q.size()), 32'd0);
    consume("unshift_consume_wen");

    // Overwrite while pending, second key collides with scan_read.
    exp_q.push_back(32'h31);
    send_frame(8'h16);
    wen_dropped = 1'b0;
    track_wen   = 1'b1;
    exp_q.push_back(32'h32);
    send_frame(8'h1E, 1'b0, 1'b1);
    track_wen = 1'b0;
    check_eq("ovw_wen_held", 32'(wen_dropped), 32'd0);
    check_eq("ovw_wen",      32'(bus.key_ram_wen), 32'd1);
    check_eq("ovw_wdata",    bus.key_ram_wdata, 32'h32);
    check_eq("ovw_drain",    32'(exp_q.size()), 32'd0);
    consume("ovw_consume_wen");

    // Partial frame abandoned by the timeout.
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 1'b0);
    repeat (20) @(negedge clock);
    check_eq("to_in_frame", 32'(bus.fsm_state), 32'(DATA));
    repeat (TIMEOUT - 200) @(negedge clock);
    check_eq("to_not_early", 32'(bus.fsm_state), 32'(DATA));
    repeat (400) @(negedge clock);
    check_eq("to_idle", 32'(bus.fsm_state), 32'(IDLE));
    check_eq("to_wen",  32'(bus.key_ram_wen), 32'd0);
    exp_q.push_back(32'h20);
    send_frame(8'h29);
    check_eq("to_space_drain", 32'(exp_q.size()), 32'd0);
    check_eq("to_space_wdata", bus.key_ram_wdata, 32'h20);
    consume("to_consume_wen");

    // Bad parity frame followed by a clean retransmit.
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h1C, 1'b1);
    check_eq("par_bad_wen", 32'(bus.key_ram_wen), 32'd0);
    exp_q.push_back(32'h61);
    send_frame(8'h1C);
`else
    exp_q.push_back(32'h61);
    send_frame(8'h1C, 1'b1);
`endif
    check_eq("par_drain", 32'(exp_q.size()), 32'd0);
    check_eq("par_wdata", bus.key_ram_wdata, 32'h61);
    consume("par_consume_wen");

    // Reset in the middle of a frame.
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(1'(8'h5A >> i), 1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_mid_wen",   32'(bus.key_ram_wen), 32'd0);
    check_eq("rst_mid_wdata", bus.key_ram_wdata, 32'h0);
    check_eq("rst_mid_state", 32'(bus.fsm_state), 32'(IDLE));
    exp_q.push_back(32'h0D);
    send_frame(8'h5A);
    check_eq("rst_enter_drain", 32'(exp_q.size()), 32'd0);
    check_eq("rst_enter_wdata", bus.key_ram_wdata, 32'h0D);

    repeat (4) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_writer.md
Name: ps2_key_writer

Overview:
- Keyboard-side producer for the data RAM's key bypass path: receives PS/2 frames and decodes make codes to ASCII.
- Drives key_ram_addr/key_ram_wdata/key_ram_wen so a CPU load from SCAN_ASCII_ADDR (13'h0310) returns the latest key.
- Sits in the MIPS DE2-115 top level between the PS/2 pins and the RAM.

Parameters:
- TIMEOUT_CYCLES, 5000, clock cycles without a PS/2 falling edge before a partial frame is abandoned.
- SCAN_ASCII_ADDR, 13'h0310, byte address driven on key_ram_addr.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- scan_read  in  1  pulse from top: CPU load at SCAN_ASCII_ADDR this cycle (ram_addr==0x0310 && !ram_write_enable).
- key_ram_addr  out  13  constant SCAN_ASCII_ADDR.
- key_ram_wdata  out  32  {24'h0, ascii}.
- key_ram_wen  out  1  high while an unconsumed key is pending.

Behaviour:
- Reset: key_ram_wdata=0, key_ram_wen=0, shift=0, break_pending=0, FSM=IDLE, timeout counter=0. key_ram_addr is constant and has no reset dependency.
- Input sync: ps2_clk and ps2_data each pass through a 2-FF synchronizer. A falling edge is a 1->0 transition on the synchronized clock; it is a one-cycle strobe.
- Frame FSM, sampling ps2_data on each falling edge:
  - IDLE: data 0 -> DATA with bit count 0; data 1 -> stay in IDLE.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: data 1 -> frame valid, emit a code for one cycle; data 0 -> frame discarded. Both return to IDLE.
- Timeout: in any state other than IDLE, the counter clears on each edge and increments otherwise. When it reaches TIMEOUT_CYCLES-1 -> IDLE, frame discarded.
- Decoder, acting on valid codes:
  - 0xE0: ignored; the next code is treated normally.
  - 0xF0: set break_pending.
  - Code with break_pending set: clear break_pending; if the code is 0x12/0x59, clear shift; otherwise no write.
  - Make 0x12/0x59: set shift; no write.
  - Other make code: look up ascii(code, shift). If nonzero, latch into key_ram_wdata[7:0] and set key_ram_wen on the next edge. Unmapped codes (table returns 0) cause no write.
- Latency: key_ram_wen rises 1 cycle after the STOP-bit edge is detected.
- Pending handling:
  - key_ram_wen stays high until a cycle with scan_read=1, then drops on the next edge. key_ram_wdata holds its value.
  - New key while pending: overwrite wdata, wen stays 1 (latest wins, no queue).
  - New key and scan_read in the same cycle: new key wins, wen stays 1.
- Reset mid-frame: the frame is lost; no partial write is ever issued.

Optional Feature:
- PS2_PARITY_CHECK_EN defined: in STOP, the frame is valid only if stop=1 AND XOR(data[7:0], parity)=1 (odd parity). Otherwise it is discarded silently.
- Undefined: the parity bit is captured and ignored.

Decomposition:
- Package ps2_key_pkg:
  - SCAN_ASCII_ADDR default.
  - Scan constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59.
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_scan_to_ascii: purely combinational set-2 lookup, (code[7:0], shift) -> ascii[7:0], 0 for unmapped.
  - Covers letters, digits, space 0x29->0x20, enter 0x5A->0x0D, and backspace 0x66->0x08.

Test Plan:
- Frame 0x1C with correct parity -> 1 cycle after STOP, key_ram_wen=1, key_ram_wdata=32'h00000061, key_ram_addr=13'h0310. Then scan_read pulse -> wen=0 next cycle, wdata still 0x61.
- Sequence 12, 1C, F0 1C, F0 12, 1C -> first write 0x41. Both F0 sequences cause no write. Second 1C writes 0x61.
- Keys 0x16 then 0x1E with no scan_read in between -> wen stays 1 throughout, wdata ends at 0x00000032. Assert scan_read in the same cycle as the second key's latch -> wen remains 1.
- Partial frame: start bit plus 4 data bits, then silence for TIMEOUT_CYCLES -> FSM returns to IDLE and wen stays 0. A following full 0x29 frame -> wdata=0x20.
- With PS2_PARITY_CHECK_EN: frame 0x1C with even parity -> no write; a correct retransmit writes 0x61. Without the macro, the same bad frame writes 0x61.
- reset asserted after the 6th data bit -> all outputs 0; a subsequent clean 0x5A frame writes 0x0D.
